// File: rtl/gfx_pkg.sv
// Shared pixel types and field helpers for the layer compositing pipeline.
package gfx_pkg;

    typedef logic [12:0] pixel_t;   // {R[12:9], G[8:5], B[4:1], A[0]}
    typedef logic [11:0] rgb_t;

    localparam int FB_W_DEFAULT     = 160;
    localparam int FB_H_DEFAULT     = 120;
    localparam int SCALE_SH_DEFAULT = 2;

    function automatic logic [3:0] px_r(input pixel_t p);
        return p[12:9];
    endfunction

    function automatic logic [3:0] px_g(input pixel_t p);
        return p[8:5];
    endfunction

    function automatic logic [3:0] px_b(input pixel_t p);
        return p[4:1];
    endfunction

    function automatic logic px_a(input pixel_t p);
        return p[0];
    endfunction

    function automatic rgb_t px_rgb(input pixel_t p);
        return {px_r(p), px_g(p), px_b(p)};
    endfunction

endpackage

// File: rtl/layer_addr_gen.sv
// One layer's frame-synchronous shadow registers, clip test and registered
// VRAM address (Stage A).
module layer_addr_gen
    import gfx_pkg::*;
#(
    parameter int COORD_W  = 12,
    parameter int SCALE_SH = SCALE_SH_DEFAULT,
    parameter int FB_W     = FB_W_DEFAULT,
    parameter int FB_H     = FB_H_DEFAULT,
    parameter int ADDR_W   = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               upd_i,
    input  logic               en_i,
    input  logic [COORD_W-1:0] pos_x_i,
    input  logic [COORD_W-1:0] pos_y_i,
    input  logic [COORD_W-1:0] hdata_i,
    input  logic [COORD_W-1:0] vdata_i,
    input  logic               valid_i,
    output logic [ADDR_W-1:0]  addr_o,
    output logic               inr_o
);

    localparam int CW1 = COORD_W + 1;
    localparam logic [CW1-1:0] FB_W_C = CW1'(FB_W);
    localparam logic [CW1-1:0] FB_H_C = CW1'(FB_H);

    logic               en_q;
    logic [COORD_W-1:0] pos_x_q;
    logic [COORD_W-1:0] pos_y_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               inr_q;

    logic [COORD_W-1:0] fb_x;
    logic [COORD_W-1:0] fb_y;
    logic signed [CW1-1:0] lx;
    logic signed [CW1-1:0] ly;
    logic               in_x;
    logic               in_y;
    logic               inr_d;
    logic [ADDR_W-1:0]  addr_d;

    // The extra sign bit keeps negative layer coordinates from aliasing
    // onto the far edge of the framebuffer.
    always_comb begin
        fb_x   = hdata_i >> SCALE_SH;
        fb_y   = vdata_i >> SCALE_SH;
        lx     = $signed({1'b0, fb_x}) - $signed({pos_x_q[COORD_W-1], pos_x_q});
        ly     = $signed({1'b0, fb_y}) - $signed({pos_y_q[COORD_W-1], pos_y_q});
        in_x   = !lx[CW1-1] && ($unsigned(lx) < FB_W_C);
        in_y   = !ly[CW1-1] && ($unsigned(ly) < FB_H_C);
        inr_d  = en_q && valid_i && in_x && in_y;
        addr_d = '0;
        if (inr_d) begin
            addr_d = ADDR_W'($unsigned(ly)) * ADDR_W'(FB_W) + ADDR_W'($unsigned(lx));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            pos_x_q <= '0;
            pos_y_q <= '0;
            addr_q  <= '0;
            inr_q   <= 1'b0;
        end else begin
            if (upd_i) begin
                en_q    <= en_i;
                pos_x_q <= pos_x_i;
                pos_y_q <= pos_y_i;
            end
            addr_q <= addr_d;
            inr_q  <= inr_d;
        end
    end

    assign addr_o = addr_q;
    assign inr_o  = inr_q;

endmodule

// File: rtl/layer_compositor.sv
// N-layer pixel pipeline: per-layer address generation, VRAM latency
// alignment, bottom-to-top 1-bit-alpha compositing and matched sync delay.
module layer_compositor
    import gfx_pkg::*;
#(
    parameter int   N_LAYERS  = 4,
    parameter int   COORD_W   = 12,
    parameter int   SCALE_SH  = SCALE_SH_DEFAULT,
    parameter int   FB_W      = FB_W_DEFAULT,
    parameter int   FB_H      = FB_H_DEFAULT,
    parameter int   ADDR_W    = 15,
    parameter int   VRAM_LAT  = 1,
    parameter rgb_t BG_RGB    = 12'h000,
    parameter logic SYNC_IDLE = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [COORD_W-1:0]           hdata_i,
    input  logic [COORD_W-1:0]           vdata_i,
    input  logic                         valid_i,
    input  logic                         hsync_i,
    input  logic                         vsync_i,
    input  logic [N_LAYERS-1:0]          layer_en_i,
    input  logic [N_LAYERS*COORD_W-1:0]  pos_x_i,
    input  logic [N_LAYERS*COORD_W-1:0]  pos_y_i,
    output logic [N_LAYERS*ADDR_W-1:0]   vram_addr_o,
    input  logic [N_LAYERS*13-1:0]       vram_data_i,
    output logic [3:0]                   r_o,
    output logic [3:0]                   g_o,
    output logic [3:0]                   b_o,
    output logic                         hsync_o,
    output logic                         vsync_o
);

    logic                vs_prev_q;
    logic                upd;
    logic [N_LAYERS-1:0] inr_a;
    logic [N_LAYERS-1:0] inr_c;
    pixel_t [N_LAYERS-1:0] px_c;

    // Bit 0 is Stage A; the remaining VRAM_LAT bits cover the read latency.
    logic [VRAM_LAT:0]   vld_p_q;
    logic [VRAM_LAT:0]   hs_p_q;
    logic [VRAM_LAT:0]   vs_p_q;

    logic [N_LAYERS-1:0] vld_c_q;
    logic [N_LAYERS-1:0] hs_c_q;
    logic [N_LAYERS-1:0] vs_c_q;
    rgb_t [N_LAYERS-1:0] col_q;

    // Previous vsync resets high so a line held high through reset is not
    // mistaken for a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q <= 1'b1;
        end else begin
            vs_prev_q <= vsync_i;
        end
    end

    assign upd = vsync_i && !vs_prev_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_LAYERS; gi++) begin : g_layer
            localparam int IW = VRAM_LAT + gi;

            logic [IW-1:0] inr_sr_q;

            layer_addr_gen #(
                .COORD_W  (COORD_W),
                .SCALE_SH (SCALE_SH),
                .FB_W     (FB_W),
                .FB_H     (FB_H),
                .ADDR_W   (ADDR_W)
            ) u_addr_gen (
                .clk      (clk),
                .rst_n    (rst_n),
                .upd_i    (upd),
                .en_i     (layer_en_i[gi]),
                .pos_x_i  (pos_x_i[gi*COORD_W +: COORD_W]),
                .pos_y_i  (pos_y_i[gi*COORD_W +: COORD_W]),
                .hdata_i  (hdata_i),
                .vdata_i  (vdata_i),
                .valid_i  (valid_i),
                .addr_o   (vram_addr_o[gi*ADDR_W +: ADDR_W]),
                .inr_o    (inr_a[gi])
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    inr_sr_q <= '0;
                end else begin
                    inr_sr_q[0] <= inr_a[gi];
                    for (int j = 1; j < IW; j++) begin
                        inr_sr_q[j] <= inr_sr_q[j-1];
                    end
                end
            end

            assign inr_c[gi] = inr_sr_q[IW-1];

            if (gi == 0) begin : g_nodly
                assign px_c[gi] = vram_data_i[gi*13 +: 13];
            end else begin : g_dly
                pixel_t px_sr_q [gi];

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int j = 0; j < gi; j++) begin
                            px_sr_q[j] <= '0;
                        end
                    end else begin
                        px_sr_q[0] <= vram_data_i[gi*13 +: 13];
                        for (int j = 1; j < gi; j++) begin
                            px_sr_q[j] <= px_sr_q[j-1];
                        end
                    end
                end

                assign px_c[gi] = px_sr_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p_q <= '0;
            hs_p_q  <= {(VRAM_LAT+1){SYNC_IDLE}};
            vs_p_q  <= {(VRAM_LAT+1){SYNC_IDLE}};
        end else begin
            vld_p_q <= {vld_p_q[VRAM_LAT-1:0], valid_i};
            hs_p_q  <= {hs_p_q[VRAM_LAT-1:0], hsync_i};
            vs_p_q  <= {vs_p_q[VRAM_LAT-1:0], vsync_i};
        end
    end

    // Stage k keeps the colour from below unless layer k is opaque here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            vld_c_q <= '0;
            hs_c_q  <= {N_LAYERS{SYNC_IDLE}};
            vs_c_q  <= {N_LAYERS{SYNC_IDLE}};
        end else begin
            col_q[0]   <= (inr_c[0] && px_a(px_c[0])) ? px_rgb(px_c[0]) : BG_RGB;
            vld_c_q[0] <= vld_p_q[VRAM_LAT];
            hs_c_q[0]  <= hs_p_q[VRAM_LAT];
            vs_c_q[0]  <= vs_p_q[VRAM_LAT];
            for (int k = 1; k < N_LAYERS; k++) begin
                col_q[k]   <= (inr_c[k] && px_a(px_c[k])) ? px_rgb(px_c[k]) : col_q[k-1];
                vld_c_q[k] <= vld_c_q[k-1];
                hs_c_q[k]  <= hs_c_q[k-1];
                vs_c_q[k]  <= vs_c_q[k-1];
            end
        end
    end

    assign {r_o, g_o, b_o} = vld_c_q[N_LAYERS-1] ? col_q[N_LAYERS-1] : 12'h000;
    assign hsync_o = hs_c_q[N_LAYERS-1];
    assign vsync_o = vs_c_q[N_LAYERS-1];

endmodule
